bus_rr_matrix: RTL and testbench
================================

// Module: bus_rr_matrix
// PURPOSE
//  Parametrised successor to the single-master, two-slave system bus.
//  Arbitrates NUM_M masters with a round-robin, lock-while-requesting policy.
//  Routes the owning master to one of NUM_S slaves (RAM, accelerator cores, ...) by address decode.
//  Returns read data through a registered select with 1-cycle latency, matching synchronous slaves.
// PARAMETERS
//  NUM_M    2    number of masters (1..8)
//  NUM_S    4    number of slaves (1..16)
//  ADDR_W   16   address width
//  DATA_W   64   data width
//  DEC_LSB  12   lowest address bit used for slave decode; slave i owns addr[ADDR_W-1:DEC_LSB]==i
// PORTS
//  clk       in   1             system clock, rising edge
//  reset     in   1             asynchronous, active-high reset
//  m_req     in   NUM_M         per-master bus request; hold high to keep ownership
//  m_wr      in   NUM_M         per-master write strobe (1=write, 0=read)
//  m_addr    in   NUM_M*ADDR_W  per-master address, master k at [k*ADDR_W +: ADDR_W]
//  m_dout    in   NUM_M*DATA_W  per-master write data
//  m_grant   out  NUM_M         one-hot ownership (all-zero when idle)
//  m_din     out  DATA_W        shared read-data bus
//  m_rvalid  out  NUM_M         one-hot: m_din valid for that master this cycle
//  m_err     out  1             decode-error pulse (see CONFIGURATION)
//  s_sel     out  NUM_S         one-hot slave select
//  s_wr      out  1             write strobe to slaves
//  s_addr    out  ADDR_W        address to slaves (full width; slaves slice their low bits)
//  s_din     out  DATA_W        write data to slaves
//  s_dout    in   NUM_S*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset: m_grant=0, owner invalid, RR pointer=0, m_rvalid=0, m_din=0, m_err=0, rd_sel reg cleared.
//  Arbitration is evaluated every rising edge; m_grant is a registered output:
//   - owner valid and m_req[owner]=1: keep owner (lock).
//   - otherwise: grant to the first requester at or after ptr, searching modulo NUM_M.
//     Set ptr = winner+1 (wrap to 0). If there are no requesters, m_grant=0.
//   - a request in cycle t reaches m_grant at edge t+1; handover needs no idle cycle.
//   - owner drops its request in cycle t: no slave access occurs in cycle t.
//  Transfer phase (combinational from owner):
//   - an access occurs in any cycle with m_grant[k]=1 and m_req[k]=1.
//   - s_sel[i]=1 iff access and addr[ADDR_W-1:DEC_LSB]==i; s_wr, s_addr, s_din are muxed from owner k.
//   - when there is no access, s_sel=0, s_wr=0, and s_addr/s_din are 0.
//  Read return:
//   - a read access in cycle t registers (slave index, master k).
//   - in cycle t+1: m_din = s_dout[idx], m_rvalid[k]=1.
//   - back-to-back reads, including reads to different slaves, stream one word per cycle.
//   - writes produce no m_rvalid.
//  Unmapped address: decode index >= NUM_S. s_sel=0 and no slave is touched.
//   The read returns m_din=0 with m_rvalid[k]=1 in t+1.
//  Simultaneous events:
//   - owner releases while others request: ownership moves to the next RR requester at the next edge.
//   - a read issued in the owner's last cycle still returns in t+1 to that master.
//  Reset mid-transfer: all state clears immediately; a pending read return is dropped.
// CONFIGURATION
//  BUS_DECERR_EN defined:
//   - an unmapped access asserts m_err for 1 cycle in t+1, aligned with m_rvalid for reads.
//   - a saturating 16-bit decode-error counter is maintained, readable via hierarchy for debug.
//  BUS_DECERR_EN undefined: m_err is tied 0, there is no counter, and unmapped accesses are silent.
// STRUCTURE
//  bus_pkg:
//   - localparam helpers: clog2 for master and slave index widths.
//   - typedef of the read-return record {valid, slave idx, master idx}.
//  Sub-module bus_rr_arbiter:
//   - req/lock in, registered one-hot grant and owner index out; holds the RR pointer.
//  Top level holds the decode, the muxes and the read-return register.
// TESTING
//  Single master (k=0): write 0x1122 to 0x0010, then read 0x0010.
//   -> s_sel=4'b0001 on both accesses; m_rvalid[0] and m_din=0x1122 one cycle after the read.
//  Masters 0 and 1 request in the same cycle from reset.
//   -> master 0 granted first; it drops m_req; master 1 granted at the next edge, with no bubble.
//  Lock: master 1 holds m_req for 5 cycles while master 0 requests. -> master 0 stays ungranted until release.
//  Back-to-back reads to 0x1000 then 0x3004.
//   -> m_din carries slave 1 data, then slave 3 data, in consecutive cycles.
//  Read 0x5000 (unmapped, NUM_S=4).
//   -> s_sel=0; m_din=0 with m_rvalid; m_err=1 only with BUS_DECERR_EN.
//  Assert reset during a granted read. -> m_grant, m_rvalid and m_err are 0 in the same cycle; no stale return after release.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared index-width helper and read-return record for bus_rr_matrix.
`default_nettype none

package bus_pkg;

  localparam int MIDX_W = 3;  // up to 8 masters
  localparam int SIDX_W = 4;  // up to 16 slaves

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic              valid;
    logic              hit;
    logic [SIDX_W-1:0] sidx;
    logic [MIDX_W-1:0] midx;
  } rd_ret_t;

endpackage

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin arbiter that locks onto the owner while it keeps requesting.
// Rev 1.0
`default_nettype none

module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_M-1:0]           req,
  output logic [NUM_M-1:0]           grant,
  output logic [idx_w(NUM_M)-1:0]    owner,
  output logic                       owner_vld
);

  localparam int MW = idx_w(NUM_M);

  logic [MW-1:0]    r_ptr;
  logic [MW-1:0]    r_owner;
  logic [NUM_M-1:0] r_grant;
  logic [MW-1:0]    w_win;
  logic             w_found;
  logic             w_lock;
  int               w_j;

  // First requester at or after the pointer, searching modulo NUM_M.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_j     = 0;
    for (int i = 0; i < NUM_M; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NUM_M) w_j = w_j - NUM_M;
      if (!w_found && req[MW'(w_j)]) begin
        w_found = 1'b1;
        w_win   = MW'(w_j);
      end
    end
  end

  assign w_lock = (|r_grant) && req[r_owner];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else if (!w_lock) begin
      if (w_found) begin
        r_grant <= NUM_M'(1) << w_win;
        r_owner <= w_win;
        r_ptr   <= (int'(w_win) == NUM_M - 1) ? '0 : w_win + 1'b1;
      end else begin
        r_grant <= '0;
      end
    end
  end

  assign grant     = r_grant;
  assign owner     = r_owner;
  assign owner_vld = |r_grant;

endmodule

`default_nettype wire

// File: rtl/bus_rr_matrix.sv
// bus_rr_matrix: NUM_M-master / NUM_S-slave bus with RR arbitration and 1-cycle read return.
// Optional BUS_DECERR_EN: decode-error pulse on m_err plus a saturating 16-bit error counter.
`default_nettype none

module bus_rr_matrix
  import bus_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int DEC_LSB = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_M-1:0]         m_req,
  input  logic [NUM_M-1:0]         m_wr,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M*DATA_W-1:0]  m_dout,
  output logic [NUM_M-1:0]         m_grant,
  output logic [DATA_W-1:0]        m_din,
  output logic [NUM_M-1:0]         m_rvalid,
  output logic                     m_err,
  output logic [NUM_S-1:0]         s_sel,
  output logic                     s_wr,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_din,
  input  logic [NUM_S*DATA_W-1:0]  s_dout
);

  localparam int MW = idx_w(NUM_M);
  localparam int DW = ADDR_W - DEC_LSB;

  logic [MW-1:0]     w_owner;
  logic              w_owner_vld;
  logic              w_access;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DW-1:0]     w_dec;
  logic              w_hit;
  logic [SIDX_W-1:0] w_sidx;
  rd_ret_t           r_ret;

  bus_rr_arbiter #(.NUM_M(NUM_M)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (m_req),
    .grant     (m_grant),
    .owner     (w_owner),
    .owner_vld (w_owner_vld)
  );

  // An owner that has dropped its request performs no access this cycle.
  assign w_access = w_owner_vld && m_req[w_owner];
  assign w_wr     = m_wr[w_owner];
  assign w_addr   = m_addr[w_owner*ADDR_W +: ADDR_W];
  assign w_wdata  = m_dout[w_owner*DATA_W +: DATA_W];
  assign w_dec    = w_addr[ADDR_W-1:DEC_LSB];

  always_comb begin
    w_hit  = 1'b0;
    w_sidx = '0;
    s_sel  = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (32'(w_dec) == i) begin
        w_hit    = 1'b1;
        w_sidx   = SIDX_W'(i);
        s_sel[i] = w_access;
      end
    end
  end

  assign s_wr   = w_access & w_wr;
  assign s_addr = w_access ? w_addr  : '0;
  assign s_din  = w_access ? w_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ret <= '0;
    end else begin
      r_ret.valid <= w_access & ~w_wr;
      r_ret.hit   <= w_hit;
      r_ret.sidx  <= w_sidx;
      r_ret.midx  <= MIDX_W'(w_owner);
    end
  end

  // Unmapped reads return zero rather than any slave's data.
  always_comb begin
    m_din = '0;
    if (r_ret.valid && r_ret.hit) m_din = s_dout[r_ret.sidx*DATA_W +: DATA_W];
  end

  always_comb begin
    m_rvalid = '0;
    for (int k = 0; k < NUM_M; k++) begin
      m_rvalid[k] = r_ret.valid && (32'(r_ret.midx) == k);
    end
  end

`ifdef BUS_DECERR_EN
  logic        r_err;
  logic [15:0] r_decerr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err        <= 1'b0;
      r_decerr_cnt <= '0;
    end else begin
      r_err <= w_access & ~w_hit;
      if (w_access && !w_hit && r_decerr_cnt != 16'hFFFF) r_decerr_cnt <= r_decerr_cnt + 16'd1;
    end
  end

  assign m_err = r_err;
`else
  assign m_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_matrix.sv
// tb_bus_rr_matrix: directed stimulus with a read-return scoreboard for bus_rr_matrix.
`default_nettype none

module tb_bus_rr_matrix;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int AW = 16;
  localparam int DW = 64;
`ifdef BUS_DECERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_wr;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_dout;
  logic [NM-1:0]    m_grant;
  logic [DW-1:0]    m_din;
  logic [NM-1:0]    m_rvalid;
  logic             m_err;
  logic [NS-1:0]    s_sel;
  logic             s_wr;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_din;
  logic [NS*DW-1:0] s_dout;

  bus_rr_matrix #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .DEC_LSB(12)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din), .m_rvalid(m_rvalid), .m_err(m_err),
    .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_cur;
  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] em [NS][64];

  function automatic logic [63:0] pat(input int i, input int j);
    return 64'hC0DE_0000_0000_0000 | 64'(i << 8) | 64'(j);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Synchronous slave memories: one-cycle read latency.
  logic [63:0] s_mem [NS][64];
  logic [63:0] r_sdout [NS];
  bit          r_init;

  always @(posedge clk) begin
    if (!r_init) begin
      for (int i = 0; i < NS; i++)
        for (int j = 0; j < 64; j++) s_mem[i][j] <= pat(i, j);
      r_init <= 1'b1;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (s_sel[i]) begin
          if (s_wr) s_mem[i][s_addr[5:0]] <= s_din;
          else      r_sdout[i] <= s_mem[i][s_addr[5:0]];
        end
      end
    end
  end

  assign s_dout = {r_sdout[3], r_sdout[2], r_sdout[1], r_sdout[0]};

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_rvalid != '0) begin
        if (sb.size() == 0) begin
          check("stale_rvalid", 64'(m_rvalid), 64'd0);
        end else begin
          e_cur = sb.pop_front();
          check("rvalid", 64'(m_rvalid), 64'd1 << e_cur.m);
          check("rdata", m_din, e_cur.d);
          check("rerr", 64'(m_err), 64'(e_cur.e));
        end
      end else begin
        check("err_idle", 64'(m_err), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic wr,
                       input logic [15:0] addr, input logic [63:0] data);
    m_req[m]          = req;
    m_wr[m]           = wr;
    m_addr[m*AW +: AW] = addr;
    m_dout[m*DW +: DW] = data;
  endtask

  task automatic push(input int m, input logic [63:0] d, input logic e);
    exp_t x;
    x.m = m; x.d = d; x.e = e;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 64; j++) em[i][j] = pat(i, j);
    m_wr = '0; m_addr = '0; m_dout = '0;
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_grant", 64'(m_grant), 64'd0);
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_din", m_din, 64'd0);
    check("rst_err", 64'(m_err), 64'd0);
    check("rst_sel", 64'(s_sel), 64'd0);
    tick();
    reset = 1'b0;

    // Single master write then read.
    drive(0, 1'b1, 1'b1, 16'h0010, 64'h1122);
    tick();
    @(negedge clk);
    check("wr_grant", 64'(m_grant), 64'd1);
    check("wr_sel", 64'(s_sel), 64'b0001);
    check("wr_swr", 64'(s_wr), 64'd1);
    check("wr_sdin", s_din, 64'h1122);
    em[0][16] = 64'h1122;
    tick();
    drive(0, 1'b1, 1'b0, 16'h0010, 64'h0);
    @(negedge clk);
    check("rd_sel", 64'(s_sel), 64'b0001);
    check("rd_swr", 64'(s_wr), 64'd0);
    push(0, em[0][16], 1'b0);
    tick();
    m_req[0] = 1'b0;
    @(negedge clk);
    check("drop_nosel", 64'(s_sel), 64'd0);
    tick();
    @(negedge clk);
    check("idle_grant", 64'(m_grant), 64'd0);

    // Simultaneous requests from reset, then handover and lock.
    do_reset();
    drive(0, 1'b1, 1'b0, 16'h0020, 64'h0);
    drive(1, 1'b1, 1'b0, 16'h1008, 64'h0);
    tick();
    @(negedge clk);
    check("sim_grant0", 64'(m_grant), 64'b01);
    check("sim_sel0", 64'(s_sel), 64'b0001);
    push(0, em[0][32], 1'b0);
    tick();
    m_req[0] = 1'b0;
    @(negedge clk);
    check("drop_grant", 64'(m_grant), 64'b01);
    check("drop_sel", 64'(s_sel), 64'd0);
    tick();
    drive(0, 1'b1, 1'b0, 16'h0010, 64'h0);
    @(negedge clk);
    check("hand_grant1", 64'(m_grant), 64'b10);
    check("hand_sel1", 64'(s_sel), 64'b0010);
    push(1, em[1][8], 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      check("lock_grant", 64'(m_grant), 64'b10);
      push(1, em[1][8], 1'b0);
    end
    tick();
    m_req[1] = 1'b0;
    @(negedge clk);
    check("rel_grant", 64'(m_grant), 64'b10);
    check("rel_sel", 64'(s_sel), 64'd0);
    tick();
    @(negedge clk);
    check("post_grant0", 64'(m_grant), 64'b01);
    check("post_sel0", 64'(s_sel), 64'b0001);
    push(0, em[0][16], 1'b0);

    // Back-to-back reads to different slaves.
    tick();
    m_addr[0 +: AW] = 16'h1000;
    @(negedge clk);
    check("b2b_sel1", 64'(s_sel), 64'b0010);
    push(0, em[1][0], 1'b0);
    tick();
    m_addr[0 +: AW] = 16'h3004;
    @(negedge clk);
    check("b2b_sel3", 64'(s_sel), 64'b1000);
    push(0, em[3][4], 1'b0);

    // Unmapped read.
    tick();
    m_addr[0 +: AW] = 16'h5000;
    @(negedge clk);
    check("unmap_sel", 64'(s_sel), 64'd0);
    push(0, 64'd0, EXP_ERR);
    tick();
    m_req[0] = 1'b0;
    tick();
    tick();

    // Reset asserted during a granted read.
    drive(0, 1'b1, 1'b0, 16'h0010, 64'h0);
    tick();
    @(negedge clk);
    check("mid_grant", 64'(m_grant), 64'b01);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_grant", 64'(m_grant), 64'd0);
    check("mid_rst_rvalid", 64'(m_rvalid), 64'd0);
    check("mid_rst_err", 64'(m_err), 64'd0);
    m_req = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
